bit_ram_arbiter: RTL and testbench
==================================

# bit_ram_arbiter

Two-port arbiter and sequencer for the single-ported bit RAM. It shares the RAM between the instruction pipeline (port 0) and a peripheral/IO-scan engine (port 1), and drives the RAM's enable, read/write, data and address pins. It handles the RAM's registered-read latency and adds atomic read-modify-write ops (toggle, test-and-set) that the RAM cannot do itself.

## Interface
- `ADDR_W`, default 8: bit-RAM address width; must equal the RAM's address width.
- `ARB_MODE`, default 1: 0 = fixed priority (port 0 always wins), 1 = round-robin.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `p0_req`, `p1_req`  in  1  request; each cycle it is high in IDLE is a new transaction.
- `p0_op`, `p1_op`  in  2  operation: 00 READ, 01 WRITE, 10 TOGGLE, 11 TEST_SET.
- `p0_addr`, `p1_addr`  in  ADDR_W  bit address.
- `p0_wdata`, `p1_wdata`  in  1  write data; used by WRITE only.
- `p0_ack`, `p1_ack`  out  1  one-cycle pulse: request accepted, and op/addr/wdata captured.
- `p0_rdata`, `p1_rdata`  out  1  read data; returns the old bit for TOGGLE and TEST_SET.
- `p0_rvalid`, `p1_rvalid`  out  1  one-cycle pulse qualifying rdata.
- `ram_en`, `ram_rw`  out  1  RAM enable; rw = 1 read, 0 write.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_din`  out  1  RAM write data.
- `ram_dout`  in  1  RAM registered read output; Z while the RAM is disabled.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: arbitrate; if any request, latch winner/op/addr/wdata → ISSUE.
  - ISSUE: ack winner; drive RAM per op; WRITE → IDLE; others → RD_WAIT.
  - RD_WAIT: keep ram_en=1, ram_rw=1, same addr; capture ram_dout at end of cycle; READ → IDLE; TOGGLE/TEST_SET → WR_BACK.
  - WR_BACK: ram_en=1, ram_rw=0; ram_din = ~captured bit (TOGGLE) or 1 (TEST_SET) → IDLE.
- RAM drive per op in ISSUE: WRITE drives ram_en=1, ram_rw=0, ram_din=wdata. All other ops drive ram_en=1, ram_rw=1.
- rvalid for the granted port: pulses in the IDLE cycle after RD_WAIT for READ, and in the WR_BACK cycle for RMW ops.
- rdata holds its value until the next capture.
- The non-granted port sees no ack, rdata or rvalid change.
- Arbitration, round-robin mode: on simultaneous requests, the port not granted last wins; `last_grant` updates on every grant.
- Arbitration, fixed mode: port 0 wins on simultaneous requests.
- A losing request stays pending (req held) and is served next.
- ram_en=0 in IDLE; ram_addr/ram_din hold their last values.
- RD_WAIT deliberately re-reads the same address so ram_dout never goes Z during capture.
- RMW atomicity: no grant is made between an RMW's read and its write-back.

## Timing
- All outputs are registered. Reset values: every ack, rvalid and rdata = 0; ram_en=0, ram_rw=1, ram_addr=0, ram_din=0; busy=0; state=IDLE; last_grant=1 (port 0 wins first).
- Request sampled in IDLE cycle T.
- WRITE: ack and RAM write in T+1; back in IDLE at T+2; 2-cycle throughput.
- READ: ack in T+1; RD_WAIT in T+2; rvalid/rdata in T+3; 3-cycle throughput.
- TOGGLE/TEST_SET: ack in T+1; capture at end of T+2; write-back plus rvalid in T+3; IDLE at T+4.
- Back-to-back requests: a request held through the IDLE cycle after its transaction completes is a new transaction. Requesters drop req in that cycle if done.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. An RMW reset before WR_BACK leaves the bit unmodified. An in-flight read returns no rvalid.

## Structure
- Shared defines (`defines.v`): op code constants (READ/WRITE/TOGGLE/TEST_SET), state encoding, default ADDR_W.
- One sub-module: `rr_arb2`, a 2-way arbiter with `mode` input and `last_grant` register, producing a one-hot grant.
- FSM, request latching and RAM drive stay in the top module.

## Test plan
- Port 0 WRITE addr 5 data 1, then READ addr 5 → ack at T+1, RAM written at T+1; READ gives rvalid at T+3 with rdata=1.
- Both ports request READ of addr 3 (value 0) and addr 7 (value 1) in the same cycle, ARB_MODE=1 → port 0 served first (rdata 0). Port 1 acked 3 cycles later (rdata 1). Repeat → port 1 served first.
- ARB_MODE=0, both ports held requesting continuously → port 1 never acked while port 0 requests; port 1 acked in the first IDLE after port 0 drops req.
- TOGGLE addr 9 (initially 1) → rdata=1 with rvalid at T+3; ram_din=0 written at T+3; a subsequent READ returns 0. TEST_SET on a 0 bit → rdata=0, bit becomes 1.
- Port 1 TOGGLE on addr 9 while port 0 requests WRITE to addr 9 → port 0 not acked until after WR_BACK; final value equals port 0's wdata.
- Assert reset during RD_WAIT of a TOGGLE → all outputs 0 next cycle, no rvalid, bit unchanged on re-read.

Source files
------------

// File: rtl/bit_ram_arbiter_pkg.sv
// Shared definitions for the bit-RAM arbiter: operation codes, sequencer
// states and the default address width.
package bit_ram_arbiter_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        OP_READ     = 2'b00,
        OP_WRITE    = 2'b01,
        OP_TOGGLE   = 2'b10,
        OP_TEST_SET = 2'b11
    } opCode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ISSUE   = 2'b01,
        RD_WAIT = 2'b10,
        WR_BACK = 2'b11
    } arbState_e;

endpackage

// File: rtl/bit_ram_arbiter_rr_arb2.sv
// Two-way arbiter: fixed priority (port 0) or round-robin on a last-grant
// register. Grant is combinational and one-hot; lastGrant updates on accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic lastGrant;

    always_comb begin
        grant = req;
        // Contention: round-robin favours the port that did not win last time.
        if (req[0] && req[1]) begin
            if (mode && !lastGrant) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrant <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            lastGrant <= grant[1];
        end
    end

endmodule

// File: rtl/bit_ram_arbiter.sv
// Two-port sequencer for the single-ported bit RAM: arbitrates, hides the
// registered-read latency and performs atomic toggle / test-and-set.
module bit_ram_arbiter
    import bit_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned ARB_MODE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic [1:0]        p0_op,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic              p0_wdata,
    output logic              p0_ack,
    output logic              p0_rdata,
    output logic              p0_rvalid,
    input  logic              p1_req,
    input  logic [1:0]        p1_op,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic              p1_wdata,
    output logic              p1_ack,
    output logic              p1_rdata,
    output logic              p1_rvalid,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_din,
    input  logic              ram_dout,
    output logic              busy
);

    arbState_e         state, stateNext;
    opCode_e           opReg, opNext, reqOp;
    logic              winner, winnerNext;
    logic [1:0]        grant;
    logic [1:0]        ackNext, rvalidNext, rdataNext;
    logic              ramEnNext, ramRwNext, ramDinNext, busyNext;
    logic [ADDR_W-1:0] ramAddrNext, reqAddr;
    logic              reqWdata;

    rr_arb2 uArb (
        .clk    (clk),
        .reset  (reset),
        .mode   (ARB_MODE != 0),
        .req    ({p1_req, p0_req}),
        .accept (state == IDLE),
        .grant  (grant)
    );

    always_comb begin
        reqOp    = grant[1] ? opCode_e'(p1_op) : opCode_e'(p0_op);
        reqAddr  = grant[1] ? p1_addr : p0_addr;
        reqWdata = grant[1] ? p1_wdata : p0_wdata;
    end

    // Outputs are registered, so each branch computes what the next state drives.
    always_comb begin
        stateNext   = state;
        opNext      = opReg;
        winnerNext  = winner;
        ackNext     = 2'b00;
        rvalidNext  = 2'b00;
        rdataNext   = {p1_rdata, p0_rdata};
        ramEnNext   = 1'b0;
        ramRwNext   = ram_rw;
        ramAddrNext = ram_addr;
        ramDinNext  = ram_din;
        case (state)
            IDLE: begin
                if (grant != 2'b00) begin
                    stateNext   = ISSUE;
                    opNext      = reqOp;
                    winnerNext  = grant[1];
                    ackNext     = grant;
                    ramEnNext   = 1'b1;
                    ramAddrNext = reqAddr;
                    if (reqOp == OP_WRITE) begin
                        ramRwNext  = 1'b0;
                        ramDinNext = reqWdata;
                    end else begin
                        ramRwNext = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (opReg == OP_WRITE) begin
                    stateNext = IDLE;
                end else begin
                    // Re-read the same address so ram_dout stays driven for capture.
                    stateNext = RD_WAIT;
                    ramEnNext = 1'b1;
                    ramRwNext = 1'b1;
                end
            end
            RD_WAIT: begin
                rdataNext[winner]  = ram_dout;
                rvalidNext[winner] = 1'b1;
                if (opReg == OP_READ) begin
                    stateNext = IDLE;
                end else begin
                    stateNext  = WR_BACK;
                    ramEnNext  = 1'b1;
                    ramRwNext  = 1'b0;
                    ramDinNext = (opReg == OP_TOGGLE) ? ~ram_dout : 1'b1;
                end
            end
            WR_BACK: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        busyNext = (stateNext != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            opReg     <= OP_READ;
            winner    <= 1'b0;
            p0_ack    <= 1'b0;
            p1_ack    <= 1'b0;
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= 1'b0;
            p1_rdata  <= 1'b0;
            ram_en    <= 1'b0;
            ram_rw    <= 1'b1;
            ram_addr  <= '0;
            ram_din   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= stateNext;
            opReg     <= opNext;
            winner    <= winnerNext;
            p0_ack    <= ackNext[0];
            p1_ack    <= ackNext[1];
            p0_rvalid <= rvalidNext[0];
            p1_rvalid <= rvalidNext[1];
            p0_rdata  <= rdataNext[0];
            p1_rdata  <= rdataNext[1];
            ram_en    <= ramEnNext;
            ram_rw    <= ramRwNext;
            ram_addr  <= ramAddrNext;
            ram_din   <= ramDinNext;
            busy      <= busyNext;
        end
    end

endmodule

// File: tb/tb_bit_ram_arbiter.sv
// Scoreboard bench: instance 0 runs round-robin, instance 1 fixed priority,
// each against its own registered-read bit-RAM model.
module tb_bit_ram_arbiter;
    import bit_ram_arbiter_pkg::*;

    localparam int BOUND = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rst;
    logic [1:0][1:0]       req, wdata, ack, rdata, rvalid;
    logic [1:0][1:0][1:0]  op;
    logic [1:0][1:0][7:0]  addr;
    logic [1:0]            ramEn, ramRw, ramDin, ramDout, busy;
    logic [1:0][7:0]       ramAddr;
    logic                  mem0 [256];
    logic                  mem1 [256];

    int cyc = 0;
    int nChecks = 0;
    int nFail = 0;

    typedef struct {
        bit   isRv;
        int   port;
        logic data;
        int   atCyc;
    } ev_t;
    ev_t expQ0[$];
    ev_t expQ1[$];

    bit_ram_arbiter #(.ADDR_W(8), .ARB_MODE(1)) u0 (
        .clk(clk), .reset(rst[0]),
        .p0_req(req[0][0]), .p0_op(op[0][0]), .p0_addr(addr[0][0]), .p0_wdata(wdata[0][0]),
        .p0_ack(ack[0][0]), .p0_rdata(rdata[0][0]), .p0_rvalid(rvalid[0][0]),
        .p1_req(req[0][1]), .p1_op(op[0][1]), .p1_addr(addr[0][1]), .p1_wdata(wdata[0][1]),
        .p1_ack(ack[0][1]), .p1_rdata(rdata[0][1]), .p1_rvalid(rvalid[0][1]),
        .ram_en(ramEn[0]), .ram_rw(ramRw[0]), .ram_addr(ramAddr[0]), .ram_din(ramDin[0]),
        .ram_dout(ramDout[0]), .busy(busy[0])
    );

    bit_ram_arbiter #(.ADDR_W(8), .ARB_MODE(0)) u1 (
        .clk(clk), .reset(rst[1]),
        .p0_req(req[1][0]), .p0_op(op[1][0]), .p0_addr(addr[1][0]), .p0_wdata(wdata[1][0]),
        .p0_ack(ack[1][0]), .p0_rdata(rdata[1][0]), .p0_rvalid(rvalid[1][0]),
        .p1_req(req[1][1]), .p1_op(op[1][1]), .p1_addr(addr[1][1]), .p1_wdata(wdata[1][1]),
        .p1_ack(ack[1][1]), .p1_rdata(rdata[1][1]), .p1_rvalid(rvalid[1][1]),
        .ram_en(ramEn[1]), .ram_rw(ramRw[1]), .ram_addr(ramAddr[1]), .ram_din(ramDin[1]),
        .ram_dout(ramDout[1]), .busy(busy[1])
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ramEn[0]) begin
            if (ramRw[0]) ramDout[0] <= mem0[ramAddr[0]];
            else          mem0[ramAddr[0]] <= ramDin[0];
        end
        if (ramEn[1]) begin
            if (ramRw[1]) ramDout[1] <= mem1[ramAddr[1]];
            else          mem1[ramAddr[1]] <= ramDin[1];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushExp(input int g, input bit isRv, input int p, input logic d, input int at);
        ev_t e;
        e.isRv = isRv; e.port = p; e.data = d; e.atCyc = at;
        if (g == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    task automatic observe(input int g, input bit isRv, input int p, input logic d);
        ev_t e;
        bit got = 1'b0;
        if (g == 0 && expQ0.size() > 0) begin
            e = expQ0.pop_front(); got = 1'b1;
        end else if (g == 1 && expQ1.size() > 0) begin
            e = expQ1.pop_front(); got = 1'b1;
        end
        nChecks++;
        if (!got) begin
            nFail++;
            $display("FAIL event_inst%0d: got %s port%0d at cycle %0d, expected no event",
                     g, isRv ? "rvalid" : "ack", p, cyc);
        end else if (e.isRv != isRv || e.port != p || e.atCyc != cyc || (isRv && e.data !== d)) begin
            nFail++;
            $display("FAIL event_inst%0d: got %s port%0d data %0b cycle %0d, expected %s port%0d data %0b cycle %0d",
                     g, isRv ? "rvalid" : "ack", p, d, cyc,
                     e.isRv ? "rvalid" : "ack", e.port, e.data, e.atCyc);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            for (int p = 0; p < 2; p++) begin
                if (ack[g][p] === 1'b1)    observe(g, 1'b0, p, 1'b0);
                if (rvalid[g][p] === 1'b1) observe(g, 1'b1, p, rdata[g][p]);
            end
        end
    end

    task automatic xact(input int g, input int p, input logic [1:0] o, input logic [7:0] a, input logic d);
        bit got = 1'b0;
        op[g][p] = o; addr[g][p] = a; wdata[g][p] = d; req[g][p] = 1'b1;
        for (int i = 0; i < BOUND && !got; i++) begin
            @(negedge clk);
            got = (ack[g][p] === 1'b1);
        end
        req[g][p] = 1'b0;
        nChecks++;
        if (!got) begin
            nFail++;
            $display("FAIL ack_timeout inst%0d port%0d: got no ack, expected ack within %0d cycles", g, p, BOUND);
        end
    endtask

    task automatic waitIdle(input int g);
        bit idle = 1'b0;
        for (int i = 0; i < BOUND && !idle; i++) begin
            @(negedge clk);
            idle = (busy[g] === 1'b0);
        end
        if (!idle) begin
            nChecks++; nFail++;
            $display("FAIL idle_timeout inst%0d: got busy, expected idle within %0d cycles", g, BOUND);
        end
    endtask

    task automatic doXact(input int g, input int p, input logic [1:0] o, input logic [7:0] a,
                          input logic d, input logic expData);
        int c = cyc;
        pushExp(g, 1'b0, p, 1'b0, c + 1);
        if (o != OP_WRITE) pushExp(g, 1'b1, p, expData, c + 3);
        xact(g, p, o, a, d);
        waitIdle(g);
    endtask

    task automatic checkReset(input int g);
        check($sformatf("rst_ack_i%0d", g),    int'(ack[g]), 0);
        check($sformatf("rst_rvalid_i%0d", g), int'(rvalid[g]), 0);
        check($sformatf("rst_rdata_i%0d", g),  int'(rdata[g]), 0);
        check($sformatf("rst_ram_en_i%0d", g), int'(ramEn[g]), 0);
        check($sformatf("rst_ram_rw_i%0d", g), int'(ramRw[g]), 1);
        check($sformatf("rst_ram_addr_i%0d", g), int'(ramAddr[g]), 0);
        check($sformatf("rst_ram_din_i%0d", g), int'(ramDin[g]), 0);
        check($sformatf("rst_busy_i%0d", g),   int'(busy[g]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish within 100000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int  c, n;
        bit  got;
        rst = 2'b11; req = '0; op = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checkReset(0);
        checkReset(1);
        rst = 2'b00;

        // Preload through port 1 so the last grant is port 1.
        doXact(0, 1, OP_WRITE, 8'd3,  1'b0, 1'b0);
        doXact(0, 1, OP_WRITE, 8'd7,  1'b1, 1'b0);
        doXact(0, 1, OP_WRITE, 8'd9,  1'b1, 1'b0);
        doXact(0, 1, OP_WRITE, 8'd12, 1'b0, 1'b0);

        // Simultaneous reads: port 0 wins, port 1 follows three cycles later.
        c = cyc;
        pushExp(0, 1'b0, 0, 1'b0, c + 1); pushExp(0, 1'b1, 0, 1'b0, c + 3);
        pushExp(0, 1'b0, 1, 1'b0, c + 4); pushExp(0, 1'b1, 1, 1'b1, c + 6);
        fork
            xact(0, 0, OP_READ, 8'd3, 1'b0);
            xact(0, 1, OP_READ, 8'd7, 1'b0);
        join
        waitIdle(0);

        // Solo port 0 grant, then the next contention goes to port 1.
        doXact(0, 0, OP_READ, 8'd3, 1'b0, 1'b0);
        c = cyc;
        pushExp(0, 1'b0, 1, 1'b0, c + 1); pushExp(0, 1'b1, 1, 1'b1, c + 3);
        pushExp(0, 1'b0, 0, 1'b0, c + 4); pushExp(0, 1'b1, 0, 1'b0, c + 6);
        fork
            xact(0, 0, OP_READ, 8'd3, 1'b0);
            xact(0, 1, OP_READ, 8'd7, 1'b0);
        join
        waitIdle(0);

        // Write then read back.
        c = cyc;
        pushExp(0, 1'b0, 0, 1'b0, c + 1);
        xact(0, 0, OP_WRITE, 8'd5, 1'b1);
        check("wr_ram_en", int'(ramEn[0]), 1);
        check("wr_ram_rw", int'(ramRw[0]), 0);
        check("wr_ram_addr", int'(ramAddr[0]), 5);
        check("wr_ram_din", int'(ramDin[0]), 1);
        waitIdle(0);
        check("mem5_after_write", int'(mem0[5]), 1);
        doXact(0, 0, OP_READ, 8'd5, 1'b0, 1'b1);

        // Toggle a 1 bit, observing the write-back pins.
        c = cyc;
        pushExp(0, 1'b0, 0, 1'b0, c + 1); pushExp(0, 1'b1, 0, 1'b1, c + 3);
        xact(0, 0, OP_TOGGLE, 8'd9, 1'b0);
        repeat (2) @(negedge clk);
        check("wb_ram_en", int'(ramEn[0]), 1);
        check("wb_ram_rw", int'(ramRw[0]), 0);
        check("wb_ram_addr", int'(ramAddr[0]), 9);
        check("wb_ram_din", int'(ramDin[0]), 0);
        waitIdle(0);
        check("mem9_after_toggle", int'(mem0[9]), 0);
        doXact(0, 0, OP_READ, 8'd9, 1'b0, 1'b0);

        doXact(0, 0, OP_TEST_SET, 8'd12, 1'b0, 1'b0);
        check("mem12_after_tas", int'(mem0[12]), 1);

        // Port 1 toggle holds off a port 0 write to the same bit.
        c = cyc;
        pushExp(0, 1'b0, 1, 1'b0, c + 1); pushExp(0, 1'b1, 1, 1'b0, c + 3);
        pushExp(0, 1'b0, 0, 1'b0, c + 5);
        fork
            xact(0, 1, OP_TOGGLE, 8'd9, 1'b0);
            begin
                @(negedge clk);
                xact(0, 0, OP_WRITE, 8'd9, 1'b0);
            end
        join
        waitIdle(0);
        check("mem9_after_contention", int'(mem0[9]), 0);

        // Reset while a toggle sits in RD_WAIT.
        c = cyc;
        pushExp(0, 1'b0, 0, 1'b0, c + 1);
        xact(0, 0, OP_TOGGLE, 8'd9, 1'b0);
        @(negedge clk);
        check("busy_in_rd_wait", int'(busy[0]), 1);
        rst[0] = 1'b1;
        #1;
        checkReset(0);
        @(negedge clk);
        rst[0] = 1'b0;
        check("mem9_after_reset", int'(mem0[9]), 0);
        doXact(0, 0, OP_READ, 8'd9, 1'b0, 1'b0);

        // Fixed priority: port 1 starves while port 0 keeps requesting.
        c = cyc;
        pushExp(1, 1'b0, 0, 1'b0, c + 1); pushExp(1, 1'b0, 0, 1'b0, c + 3);
        pushExp(1, 1'b0, 0, 1'b0, c + 5); pushExp(1, 1'b0, 1, 1'b0, c + 7);
        op[1][0] = OP_WRITE; addr[1][0] = 8'd20; wdata[1][0] = 1'b1;
        op[1][1] = OP_WRITE; addr[1][1] = 8'd21; wdata[1][1] = 1'b1;
        req[1] = 2'b11;
        n = 0;
        for (int i = 0; i < BOUND && n < 3; i++) begin
            @(negedge clk);
            if (ack[1][0] === 1'b1) n++;
        end
        req[1][0] = 1'b0;
        check("fixed_p0_acks", n, 3);
        got = 1'b0;
        for (int i = 0; i < BOUND && !got; i++) begin
            @(negedge clk);
            got = (ack[1][1] === 1'b1);
        end
        req[1][1] = 1'b0;
        check("fixed_p1_ack", int'(got), 1);
        waitIdle(1);
        check("mem1_20", int'(mem1[20]), 1);
        check("mem1_21", int'(mem1[21]), 1);

        repeat (4) @(negedge clk);
        check("pending_events_inst0", expQ0.size(), 0);
        check("pending_events_inst1", expQ1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
